// File: rtl/pcs_tx_encoder_pipe.sv
// Multi-lane 64b/66b transmit PCS encoder: per-lane classify/sequence check (stage 1),
// optional x^58+x^39+1 scrambling and output registers (stage 2).
module pcs_tx_encoder_pipe #(
    parameter int unsigned LANES       = 2,
    parameter bit          SCRAMBLE_EN = 1'b1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                    TX_CLK,
    input  logic                    TX_RST_N,
    input  logic [64*LANES-1:0]     TXD,
    input  logic [8*LANES-1:0]      TX_C,
    input  logic                    TX_VALID,
    input  logic                    CNT_CLR,
    output logic [66*LANES-1:0]     TX_BLOCK,
    output logic                    TX_BLOCK_VALID,
    output logic [CNT_WIDTH-1:0]    ERR_CNT
);

    localparam int unsigned BLK_W = 66;
    localparam int unsigned PAY_W = 64;
    localparam logic [57:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF;
    localparam logic [BLK_W-1:0] EBLOCK = {{8{7'h1E}}, 8'h1E, 2'b01};

    typedef enum logic [2:0] {ST_INIT, ST_C, ST_D, ST_T, ST_E} tx_state_e;
    typedef enum logic [2:0] {W_C, W_S, W_D, W_T, W_E} word_e;

    function automatic logic is_ctl(input logic [7:0] b);
        return (b == 8'h07) || (b == 8'h06) || (b == 8'hFE);
    endfunction

    function automatic logic [6:0] ctl_char(input logic [7:0] b);
        case (b)
            8'h06:   return 7'h06;
            8'hFE:   return 7'h1E;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [7:0] term_type(input logic [2:0] n);
        case (n)
            3'd0:    return 8'h87;
            3'd1:    return 8'h99;
            3'd2:    return 8'hAA;
            3'd3:    return 8'hB4;
            3'd4:    return 8'hCC;
            3'd5:    return 8'hD2;
            3'd6:    return 8'hE1;
            default: return 8'hFF;
        endcase
    endfunction

    logic             s1_valid_q;
    logic [LANES-1:0] s1_err;

    for (genvar ln = 0; ln < LANES; ln++) begin : g_lane
        logic [PAY_W-1:0] d_w;
        logic [7:0]       c_w;
        word_e            wtype;
        logic [BLK_W-1:0] enc;
        tx_state_e        state_q, state_d;
        logic [BLK_W-1:0] blk_d, s1_blk_q;
        logic             err_d, s1_err_q;
        logic [57:0]      scr_q, scr_d;
        logic [PAY_W-1:0] pay_scr;
        logic [BLK_W-1:0] out_q;

        assign d_w = TXD[64*ln +: 64];
        assign c_w = TX_C[8*ln +: 8];

        // Word classification and block encoding
        always_comb begin
            logic       ctl_all;
            logic       t_ok;
            logic [2:0] t_n;
            logic       hit;
            wtype   = W_E;
            enc     = EBLOCK;
            ctl_all = 1'b1;
            t_ok    = 1'b0;
            t_n     = 3'd0;
            hit     = 1'b0;
            for (int k = 0; k < 8; k++) begin
                ctl_all = ctl_all & is_ctl(d_w[8*k +: 8]);
            end
            // Terminate: n data bytes, FD at byte n, idles above it
            for (int n = 0; n < 8; n++) begin
                hit = (c_w == 8'(8'hFF << n)) && (d_w[8*n +: 8] == 8'hFD);
                for (int k = n + 1; k < 8; k++) begin
                    hit = hit & (d_w[8*k +: 8] == 8'h07);
                end
                if (hit) begin
                    t_ok = 1'b1;
                    t_n  = 3'(n);
                end
            end
            if (c_w == 8'h00) begin
                wtype = W_D;
                enc   = {d_w, 2'b10};
            end else if (c_w == 8'h01 && d_w[7:0] == 8'hFB) begin
                wtype = W_S;
                enc   = {d_w[63:8], 8'h78, 2'b01};
            end else if (c_w == 8'hFF && ctl_all) begin
                wtype = W_C;
                enc   = {56'd0, 8'h1E, 2'b01};
                for (int k = 0; k < 8; k++) begin
                    enc[10+7*k +: 7] = ctl_char(d_w[8*k +: 8]);
                end
            end else if (t_ok) begin
                wtype = W_T;
                enc   = {56'd0, term_type(t_n), 2'b01};
                for (int k = 0; k < 7; k++) begin
                    if (k < int'(t_n)) begin
                        enc[10+8*k +: 8] = d_w[8*k +: 8];
                    end
                end
            end
        end

        // Sequencing FSM: next state and stage-1 block
        always_comb begin
            logic legal;
            state_d = state_q;
            blk_d   = EBLOCK;
            err_d   = 1'b1;
            legal   = 1'b0;
            case (state_q)
                ST_INIT, ST_C, ST_T: legal = (wtype == W_C) || (wtype == W_S);
                ST_D:                legal = (wtype == W_D) || (wtype == W_T);
                default:             legal = (wtype != W_E);
            endcase
            if (legal) begin
                blk_d = enc;
                err_d = 1'b0;
                case (wtype)
                    W_C:      state_d = ST_C;
                    W_S, W_D: state_d = ST_D;
                    W_T:      state_d = ST_T;
                    default:  state_d = ST_E;
                endcase
            end else begin
                state_d = ST_E;
            end
        end

        always_ff @(posedge TX_CLK or negedge TX_RST_N) begin
            if (!TX_RST_N) begin
                state_q  <= ST_INIT;
                s1_blk_q <= '0;
                s1_err_q <= 1'b0;
            end else if (TX_VALID) begin
                state_q  <= state_d;
                s1_blk_q <= blk_d;
                s1_err_q <= err_d;
            end
        end

        // Self-synchronising scrambler over payload bits, LSB first
        always_comb begin
            logic [57:0] s;
            s       = scr_q;
            pay_scr = '0;
            for (int j = 0; j < 64; j++) begin
                pay_scr[j] = s1_blk_q[j+2] ^ s[38] ^ s[57];
                s          = {s[56:0], pay_scr[j]};
            end
            scr_d = s;
        end

        always_ff @(posedge TX_CLK or negedge TX_RST_N) begin
            if (!TX_RST_N) begin
                scr_q <= SCR_SEED;
                out_q <= '0;
            end else if (s1_valid_q) begin
                if (SCRAMBLE_EN) begin
                    out_q <= {pay_scr, s1_blk_q[1:0]};
                    scr_q <= scr_d;
                end else begin
                    out_q <= s1_blk_q;
                end
            end
        end

        assign TX_BLOCK[66*ln +: 66] = out_q;
        assign s1_err[ln]            = s1_err_q;
    end

    always_ff @(posedge TX_CLK or negedge TX_RST_N) begin
        if (!TX_RST_N) begin
            s1_valid_q     <= 1'b0;
            TX_BLOCK_VALID <= 1'b0;
            ERR_CNT        <= '0;
        end else begin
            s1_valid_q     <= TX_VALID;
            TX_BLOCK_VALID <= s1_valid_q;
            if (CNT_CLR) begin
                ERR_CNT <= '0;
            end else if (s1_valid_q && (|s1_err) && (ERR_CNT != {CNT_WIDTH{1'b1}})) begin
                ERR_CNT <= ERR_CNT + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pcs_tx_encoder_pipe.sv
// Scoreboard bench: one scrambling DUT (16-bit counter) and one bypass DUT (2-bit counter)
// share stimulus; expected blocks come from a word-level model pushed at issue time.
module tb_pcs_tx_encoder_pipe;

    localparam int unsigned LANES = 2;
    localparam int TC = 0, TS = 1, TD = 2, TT = 3, TE = 4;
    localparam int SI = 0, SC = 1, SD = 2, ST = 3, SE = 4;
    localparam logic [65:0] EBLK = {{8{7'h1E}}, 8'h1E, 2'b01};

    typedef struct {
        logic [131:0] blk_s;
        logic [131:0] blk_p;
        bit           err;
        int           cyc;
    } item_t;

    logic           clk;
    logic           rst_n;
    logic [127:0]   txd;
    logic [15:0]    txc;
    logic           vld;
    logic           clr;
    logic [131:0]   blk_s, blk_p;
    logic           bv_s, bv_p;
    logic [15:0]    cnt_s;
    logic [1:0]     cnt_p;

    pcs_tx_encoder_pipe #(.LANES(LANES), .SCRAMBLE_EN(1'b1), .CNT_WIDTH(16)) dut_s (
        .TX_CLK(clk), .TX_RST_N(rst_n), .TXD(txd), .TX_C(txc), .TX_VALID(vld),
        .CNT_CLR(clr), .TX_BLOCK(blk_s), .TX_BLOCK_VALID(bv_s), .ERR_CNT(cnt_s));

    pcs_tx_encoder_pipe #(.LANES(LANES), .SCRAMBLE_EN(1'b0), .CNT_WIDTH(2)) dut_p (
        .TX_CLK(clk), .TX_RST_N(rst_n), .TXD(txd), .TX_C(txc), .TX_VALID(vld),
        .CNT_CLR(clr), .TX_BLOCK(blk_p), .TX_BLOCK_VALID(bv_p), .ERR_CNT(cnt_p));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    item_t        sb[$];
    int           st[LANES];
    bit           h0[$];
    bit           h1[$];
    int           exp_cnt_s, exp_cnt_p;
    logic [131:0] last_s, last_p;
    int           cyc;
    bit           armed;
    int           n_checks, n_fail;

    task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit legal(input int s, input int t);
        case (s)
            SD:      return (t == TD) || (t == TT);
            SE:      return t != TE;
            default: return (t == TC) || (t == TS);
        endcase
    endfunction

    function automatic int after(input int t);
        case (t)
            TC:      return SC;
            TT:      return ST;
            default: return SD;
        endcase
    endfunction

    function automatic int pick(input int s);
        if ($urandom_range(0, 9) >= 7) return int'($urandom_range(0, 4));
        case (s)
            SD:      return int'($urandom_range(2, 3));
            SE:      return int'($urandom_range(0, 3));
            default: return int'($urandom_range(0, 1));
        endcase
    endfunction

    // Scrambled bit = data bit ^ output bit 39 back ^ output bit 58 back in the lane's stream
    task automatic scr_step(input int ln, input logic [63:0] pin, output logic [63:0] pout);
        bit b;
        pout = '0;
        for (int j = 0; j < 64; j++) begin
            if (ln == 0) begin
                b = pin[j] ^ h0[h0.size()-39] ^ h0[h0.size()-58];
                h0.push_back(b);
                void'(h0.pop_front());
            end else begin
                b = pin[j] ^ h1[h1.size()-39] ^ h1[h1.size()-58];
                h1.push_back(b);
                void'(h1.pop_front());
            end
            pout[j] = b;
        end
    endtask

    task automatic make_word(input int ty, input int n, input logic [63:0] dat,
                             output logic [63:0] d, output logic [7:0] c, output logic [65:0] blk);
        logic [55:0] pay;
        logic [7:0]  tt;
        int          sel;
        pay = '0;
        d   = dat;
        c   = 8'h00;
        blk = EBLK;
        case (ty)
            TC: begin
                c = 8'hFF;
                for (int k = 0; k < 8; k++) begin
                    sel = int'(dat[8*k +: 8]) % 3;
                    d[8*k +: 8]   = (sel == 0) ? 8'h07 : (sel == 1) ? 8'h06 : 8'hFE;
                    pay[7*k +: 7] = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h06 : 7'h1E;
                end
                blk = {pay, 8'h1E, 2'b01};
            end
            TS: begin
                c   = 8'h01;
                d   = {dat[63:8], 8'hFB};
                blk = {dat[63:8], 8'h78, 2'b01};
            end
            TD: begin
                blk = {dat, 2'b10};
            end
            TT: begin
                c  = 8'(8'hFF << n);
                tt = (n == 0) ? 8'h87 : (n == 1) ? 8'h99 : (n == 2) ? 8'hAA : (n == 3) ? 8'hB4 :
                     (n == 4) ? 8'hCC : (n == 5) ? 8'hD2 : (n == 6) ? 8'hE1 : 8'hFF;
                for (int k = 0; k < 8; k++) begin
                    if (k < n) begin
                        pay[8*k +: 8] = dat[8*k +: 8];
                    end else if (k == n) begin
                        d[8*k +: 8] = 8'hFD;
                    end else begin
                        d[8*k +: 8] = 8'h07;
                    end
                end
                blk = {pay, tt, 2'b01};
            end
            default: begin
                if (dat[0]) begin
                    c = 8'h01;
                    d = {dat[63:8], 8'h5A};
                end else begin
                    c = 8'h0F;
                end
            end
        endcase
    endtask

    task automatic issue(input bit v, input bit c_lr,
                         input int ty0, input int n0, input logic [63:0] dat0,
                         input int ty1, input int n1, input logic [63:0] dat1);
        logic [63:0] d, sp, dat;
        logic [7:0]  c;
        logic [65:0] raw;
        item_t       it;
        int          ty, n;
        @(negedge clk);
        vld      = v;
        clr      = c_lr;
        it.err   = 1'b0;
        it.blk_s = '0;
        it.blk_p = '0;
        for (int ln = 0; ln < 2; ln++) begin
            ty  = (ln == 0) ? ty0 : ty1;
            n   = (ln == 0) ? n0 : n1;
            dat = (ln == 0) ? dat0 : dat1;
            make_word(ty, n, dat, d, c, raw);
            txd[64*ln +: 64] = d;
            txc[8*ln +: 8]   = c;
            if (v) begin
                if (legal(st[ln], ty)) begin
                    st[ln] = after(ty);
                end else begin
                    raw    = EBLK;
                    it.err = 1'b1;
                    st[ln] = SE;
                end
                scr_step(ln, raw[65:2], sp);
                it.blk_s[66*ln +: 66] = {sp, raw[1:0]};
                it.blk_p[66*ln +: 66] = raw;
            end
        end
        if (v) begin
            it.cyc = cyc;
            sb.push_back(it);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vld   = 1'b0;
        clr   = 1'b0;
        #1;
        chk("rst_blk_s", blk_s, '0);
        chk("rst_blk_p", blk_p, '0);
        chk("rst_valid", {130'd0, bv_s, bv_p}, '0);
        chk("rst_cnt", {114'd0, cnt_s, cnt_p}, '0);
        sb.delete();
        h0.delete();
        h1.delete();
        for (int i = 0; i < 58; i++) begin
            h0.push_back(1'b1);
            h1.push_back(1'b1);
        end
        for (int ln = 0; ln < 2; ln++) st[ln] = SI;
        exp_cnt_s = 0;
        exp_cnt_p = 0;
        last_s    = '0;
        last_p    = '0;
        armed     = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops one expected item whenever an output is due, tracks ERR_CNT per edge
    initial begin
        item_t it;
        bit    clr_smp, exp_v, err_now;
        forever begin
            @(posedge clk);
            cyc++;
            clr_smp = clr;
            #1;
            if (!rst_n || !armed) continue;
            err_now = 1'b0;
            exp_v   = (sb.size() > 0) && (sb[0].cyc + 2 == cyc);
            chk("valid_s", 132'(bv_s), 132'(exp_v));
            chk("valid_p", 132'(bv_p), 132'(exp_v));
            if (exp_v) begin
                it = sb.pop_front();
                chk("block_scrambled", blk_s, it.blk_s);
                chk("block_plain", blk_p, it.blk_p);
                last_s  = it.blk_s;
                last_p  = it.blk_p;
                err_now = it.err;
            end else begin
                chk("hold_s", blk_s, last_s);
                chk("hold_p", blk_p, last_p);
            end
            if (clr_smp) begin
                exp_cnt_s = 0;
                exp_cnt_p = 0;
            end else if (err_now) begin
                if (exp_cnt_s < 65535) exp_cnt_s++;
                if (exp_cnt_p < 3) exp_cnt_p++;
            end
            chk("err_cnt16", 132'(cnt_s), 132'(exp_cnt_s));
            chk("err_cnt2", 132'(cnt_p), 132'(exp_cnt_p));
        end
    end

    initial begin
        int t0, t1;
        rst_n = 1'b1;
        vld   = 1'b0;
        clr   = 1'b0;
        txd   = '0;
        txc   = '0;
        cyc   = 0;
        armed = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        do_reset();

        // Legal idle/start/data/terminate sequence on both lanes
        issue(1, 0, TC, 0, 64'h0, TC, 0, 64'h0);
        issue(1, 0, TS, 0, 64'h0706050403020100, TS, 0, 64'h0706050403020100);
        issue(1, 0, TD, 0, 64'hAAAA_AAAA_AAAA_AAAA, TD, 0, 64'hAAAA_AAAA_AAAA_AAAA);
        issue(1, 0, TT, 1, 64'h55, TT, 1, 64'h55);
        issue(0, 0, TC, 0, 64'h0, TC, 0, 64'h0);
        issue(0, 0, TC, 0, 64'h0, TC, 0, 64'h0);

        // Data straight out of reset is illegal, then idle recovers
        do_reset();
        issue(1, 0, TD, 0, 64'h0, TD, 0, 64'h0);
        issue(1, 0, TC, 0, 64'h0, TC, 0, 64'h0);

        // Lane 1 only breaks sequence
        issue(1, 0, TS, 0, 64'h1122_3344_5566_7700, TS, 0, 64'h8899_AABB_CCDD_EE00);
        issue(1, 0, TD, 0, 64'h0123_4567_89AB_CDEF, TC, 0, 64'h0);

        // Valid gap: 1,0,1 with data words
        issue(1, 0, TD, 0, 64'hDEAD_BEEF_0000_1111, TD, 0, 64'h0);
        issue(0, 0, TD, 0, 64'hFFFF_FFFF_FFFF_FFFF, TD, 0, 64'h1);
        issue(1, 0, TD, 0, 64'h0F0F_F0F0_3C3C_C3C3, TT, 7, 64'h0077_6655_4433_2211);

        // Error burst saturates the narrow counter; clear lands on an error cycle
        for (int i = 0; i < 6; i++) issue(1, 0, TE, 0, 64'(i), TE, 0, 64'(i + 1));
        issue(1, 1, TE, 0, 64'h0, TE, 0, 64'h0);
        issue(0, 0, TC, 0, 64'h0, TC, 0, 64'h0);
        issue(0, 0, TC, 0, 64'h0, TC, 0, 64'h0);

        // Randomised traffic with a mid-stream reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            t0 = pick(st[0]);
            t1 = pick(st[1]);
            issue($urandom_range(0, 9) < 8, $urandom_range(0, 29) == 0,
                  t0, int'($urandom_range(0, 7)), {$urandom, $urandom},
                  t1, int'($urandom_range(0, 7)), {$urandom, $urandom});
        end

        repeat (4) issue(0, 0, TC, 0, 64'h0, TC, 0, 64'h0);
        chk("scoreboard_drained", 132'(sb.size()), 132'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
